// File: rtl/tt_um_universal_shift_register.sv
// 8-bit universal shift register tile: hold, shift right, shift left and parallel load.
// Serial inputs arrive on ui_in, load data on uio_in, and the register drives uo_out directly.
module tt_um_universal_shift_register (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [1:0] mode_s;
  logic       serial_left_s;
  logic       serial_right_s;
  logic [7:0] q_d;
  logic [7:0] q_q;
  logic       unused_s;

  assign mode_s         = ui_in[1:0];
  assign serial_left_s  = ui_in[2];
  assign serial_right_s = ui_in[3];
  assign unused_s       = &{1'b0, ui_in[7:4]};

  // Next-state selection; ena low freezes the register whatever the mode.
  always_comb begin
    q_d = q_q;
    if (!ena) begin
      q_d = q_q;
    end else begin
      case (mode_s)
        MODE_HOLD:  q_d = q_q;
        MODE_RIGHT: q_d = {serial_left_s, q_q[7:1]};
        MODE_LEFT:  q_d = {q_q[6:0], serial_right_s};
        MODE_LOAD:  q_d = uio_in;
        default:    q_d = q_q;
      endcase
    end
  end

  // State register; rst_n is active-high and synchronous for this tile.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign uo_out  = q_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_universal_shift_register.sv
// Bench for tt_um_universal_shift_register: directed walk through the expected sequences,
// then random stimulus, all checked against a byte-level model on every falling edge.
module tb_tt_um_universal_shift_register;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int fails  = 0;

  logic [7:0] model;
  bit         model_valid = 1'b0;

  tt_um_universal_shift_register dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what the byte must become after each rising edge.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      model = 8'h00;
      model_valid = 1'b1;
    end else if (model_valid && ena === 1'b1) begin
      if (ui_in[1:0] == 2'd1)
        model = (model >> 1) + (ui_in[2] ? 8'd128 : 8'd0);
      else if (ui_in[1:0] == 2'd2)
        model = ((model * 2) % 256) + (ui_in[3] ? 8'd1 : 8'd0);
      else if (ui_in[1:0] == 2'd3)
        model = uio_in;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (uo_out !== model) begin
        fails++;
        $display("FAIL model_q t=%0t: uo_out=%02h expected %02h", $time, uo_out, model);
      end
      checks++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        fails++;
        $display("FAIL uio_tie t=%0t: uio_out=%02h uio_oe=%02h expected 00/00", $time, uio_out, uio_oe);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] pd);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = ui;
    uio_in = pd;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_lit(input logic [7:0] want, input string name);
    checks++;
    if (uo_out !== want || model !== want) begin
      fails++;
      $display("FAIL %s: uo_out=%02h model=%02h expected %02h", name, uo_out, model, want);
    end
  endtask

  initial begin
    logic [7:0] exp_v;
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

    step(1'b1, 1'b1, 8'h03, 8'hFF);
    step(1'b1, 1'b1, 8'h03, 8'hFF);
    expect_lit(8'h00, "reset");

    step(1'b0, 1'b1, 8'h03, 8'hAA); expect_lit(8'hAA, "load_aa");
    step(1'b0, 1'b1, 8'h05, 8'h00); expect_lit(8'hD5, "shr_1");
    step(1'b0, 1'b1, 8'h05, 8'h00); expect_lit(8'hEA, "shr_2");
    step(1'b0, 1'b1, 8'h0A, 8'h00); expect_lit(8'hD5, "shl_1");
    step(1'b0, 1'b1, 8'h0A, 8'h00); expect_lit(8'hAB, "shl_2");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h0C, 8'h55); expect_lit(8'hAB, "hold");
    end
    step(1'b0, 1'b0, 8'h03, 8'h3C); expect_lit(8'hAB, "ena_low");
    step(1'b0, 1'b1, 8'h03, 8'h3C); expect_lit(8'h3C, "ena_high_load");

    step(1'b0, 1'b1, 8'h03, 8'hFF); expect_lit(8'hFF, "load_ff");
    exp_v = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      exp_v = exp_v >> 1;
      step(1'b0, 1'b1, {4'($urandom_range(15, 0)), 4'h9}, 8'($urandom));
      expect_lit(exp_v, "shr_zero_fill");
    end

    step(1'b0, 1'b1, 8'h03, 8'h81); expect_lit(8'h81, "load_81");
    step(1'b0, 1'b1, 8'h0A, 8'h00); expect_lit(8'h03, "shl_81");
    step(1'b1, 1'b1, 8'h0A, 8'h00); expect_lit(8'h00, "reset_mid_shift");
    step(1'b0, 1'b1, 8'h0A, 8'h00); expect_lit(8'h01, "resume_after_reset");

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0),
           8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_universal_shift_register.md
Name: tt_um_universal_shift_register

Overview:
- 8-bit universal shift register in a TinyTapeout-style user tile.
- Four modes, selected by a 2-bit code: hold, shift right, shift left, parallel load.
- Serial inputs come in on ui_in; parallel data comes in on uio_in.
- The current register contents drive uo_out continuously.

Parameters:
- None. The register width is fixed at 8 bits.

Ports:
- clk  input  1  System clock. All state updates on the rising edge.
- rst_n  input  1  Reset, synchronous and active-high despite the _n suffix.
  - When rst_n=1 at a rising clk edge, the register clears.
  - This polarity and synchronicity are fixed for this block.
- ena  input  1  Design enable. When 0, the register holds its value.
- ui_in  input  8  Control and serial inputs:
  - [1:0] mode
  - [2] serial_in_left, which enters the MSB on a right shift
  - [3] serial_in_right, which enters the LSB on a left shift
  - [7:4] unused and ignored
- uo_out  output  8  Current register contents Q[7:0].
- uio_in  input  8  Parallel load data.
- uio_out  output  8  Tied to 8'h00.
- uio_oe  output  8  Tied to 8'h00, so all uio pins are inputs.

Behaviour:
- State: one 8-bit register Q. uo_out = Q combinationally, with no extra output register.
- Reset value: Q = 8'h00. uio_out and uio_oe are constantly 8'h00.
- Update priority at each rising clk edge, first match wins:
  1. rst_n=1 → Q <= 8'h00, regardless of ena or mode.
  2. ena=0 → Q <= Q.
  3. mode=00 (hold) → Q <= Q.
  4. mode=01 (shift right) → Q <= {ui_in[2], Q[7:1]}. Q[0] is discarded.
  5. mode=10 (shift left) → Q <= {Q[6:0], ui_in[3]}. Q[7] is discarded.
  6. mode=11 (parallel load) → Q <= uio_in.
- Latency: each operation takes exactly one clock. The new Q is visible on uo_out after the edge.
- Continuous shifting: a mode held for N cycles performs N shifts. There is no wrap-around; this is not a rotate.
- Sampling: inputs are sampled at the clock edge only. Input changes between edges have no effect until the next edge.
- Reset mid-operation: reset overrides any mode on the same edge. The operation resumes from 8'h00 on the first edge after reset deasserts.
- Bits ui_in[7:4] and the unused serial input for the active mode must not affect Q.
- No X propagation: the design must be fully defined from the first reset edge.

Test Plan:
- Reset: hold rst_n=1 for 2 edges with ena=1, mode=11, uio_in=8'hFF → uo_out=8'h00. Also check uio_oe=8'h00 and uio_out=8'h00.
- Load then shift right:
  - rst_n=0, ena=1, uio_in=8'hAA, mode=11 for 1 edge → 8'hAA.
  - mode=01, ui_in[2]=1 for 2 edges → 8'hD5, then 8'hEA.
- Shift left: from 8'hEA, mode=10, ui_in[3]=1 for 2 edges → 8'hD5, then 8'hAB.
- Hold and enable gating:
  - mode=00 for 3 edges → stays 8'hAB.
  - Then ena=0 with mode=11 and uio_in=8'h3C → stays 8'hAB.
  - Then ena=1 for 1 edge → 8'h3C.
- Serial-in zero and input isolation:
  - Load 8'hFF, then mode=01 with ui_in[2]=0 and ui_in[3]=1 for 8 edges.
  - Required sequence: 7F, 3F, 1F, 0F, 07, 03, 01, 00.
  - Toggling ui_in[7:4] during the sequence has no effect.
- Reset mid-shift: during mode=10 shifting from 8'h81, assert rst_n=1 for 1 edge → 8'h00. Deassert with mode=10 and ui_in[3]=1 → 8'h01 on the next edge.
